// File: rtl/attack_map_gather.sv
// Gathers the 128 per-square attack detector results into white/black attack maps,
// then derives check status and castling legality. Optional macro: ATTACK_MAP_COUNT_EN.

`ifndef EMPTY_POSN
`define EMPTY_POSN 4'd0
`endif
`ifndef WHITE_KING
`define WHITE_KING 4'd6
`endif
`ifndef BLACK_KING
`define BLACK_KING 4'd14
`endif

module attack_map_gather #(
    parameter int PIECE_WIDTH    = 4,
    parameter int BOARD_WIDTH    = 256,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BOARD_WIDTH-1:0] board,
    input  logic                   board_valid,
    input  logic [3:0]             castle_rights,
    input  logic [63:0]            white_attacked,
    input  logic [63:0]            white_attacked_valid,
    input  logic [63:0]            black_attacked,
    input  logic [63:0]            black_attacked_valid,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [63:0]            white_map,
    output logic [63:0]            black_map,
    output logic                   white_in_check,
    output logic                   black_in_check,
    output logic [3:0]             castle_ok,
    output logic                   timeout_err
`ifdef ATTACK_MAP_COUNT_EN
    ,
    output logic [6:0]             white_attack_count,
    output logic [6:0]             black_attack_count
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GATHER = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]             state;
    logic [BOARD_WIDTH-1:0] board_q;
    logic [3:0]             rights_q;
    logic [63:0]            sticky_w;
    logic [63:0]            sticky_b;
    logic [CNT_W-1:0]       cnt;

    logic        gathering;
    logic [63:0] white_next;
    logic [63:0] black_next;
    logic [63:0] sticky_w_next;
    logic [63:0] sticky_b_next;
    logic        all_reported;

    logic [63:0] empty_sq;
    logic        wk_found;
    logic        bk_found;
    logic [5:0]  wk_idx;
    logic [5:0]  bk_idx;
    logic        white_check_c;
    logic        black_check_c;
    logic [3:0]  castle_c;

    assign busy      = (state != S_IDLE);
    assign gathering = (state == S_GATHER);

    // Maps only move while gathering, so *_next doubles as the "final map" in EVAL.
    assign white_next    = gathering ? ((white_map & ~white_attacked_valid) | (white_attacked & white_attacked_valid))
                                     : white_map;
    assign black_next    = gathering ? ((black_map & ~black_attacked_valid) | (black_attacked & black_attacked_valid))
                                     : black_map;
    assign sticky_w_next = sticky_w | white_attacked_valid;
    assign sticky_b_next = sticky_b | black_attacked_valid;
    assign all_reported  = (&sticky_w_next) & (&sticky_b_next);

    // Descending scan so the lowest matching square wins.
    always_comb begin
        empty_sq = '0;
        wk_found = 1'b0;
        bk_found = 1'b0;
        wk_idx   = '0;
        bk_idx   = '0;
        for (int s = 63; s >= 0; s--) begin
            empty_sq[s] = (board_q[s*PIECE_WIDTH +: PIECE_WIDTH] == PIECE_WIDTH'(`EMPTY_POSN));
            if (board_q[s*PIECE_WIDTH +: PIECE_WIDTH] == PIECE_WIDTH'(`WHITE_KING)) begin
                wk_found = 1'b1;
                wk_idx   = 6'(s);
            end
            if (board_q[s*PIECE_WIDTH +: PIECE_WIDTH] == PIECE_WIDTH'(`BLACK_KING)) begin
                bk_found = 1'b1;
                bk_idx   = 6'(s);
            end
        end
    end

    assign white_check_c = wk_found & black_map[wk_idx];
    assign black_check_c = bk_found & white_map[bk_idx];

    assign castle_c[0] = rights_q[0] & ~(|black_map[6:4])   & empty_sq[5]  & empty_sq[6];
    assign castle_c[1] = rights_q[1] & ~(|black_map[4:2])   & empty_sq[1]  & empty_sq[2]  & empty_sq[3];
    assign castle_c[2] = rights_q[2] & ~(|white_map[62:60]) & empty_sq[61] & empty_sq[62];
    assign castle_c[3] = rights_q[3] & ~(|white_map[60:58]) & empty_sq[57] & empty_sq[58] & empty_sq[59];

`ifdef ATTACK_MAP_COUNT_EN
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            board_q        <= '0;
            rights_q       <= '0;
            sticky_w       <= '0;
            sticky_b       <= '0;
            cnt            <= '0;
            result_valid   <= 1'b0;
            white_map      <= '0;
            black_map      <= '0;
            white_in_check <= 1'b0;
            black_in_check <= 1'b0;
            castle_ok      <= '0;
            timeout_err    <= 1'b0;
`ifdef ATTACK_MAP_COUNT_EN
            white_attack_count <= '0;
            black_attack_count <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (board_valid) begin
                        board_q  <= board;
                        rights_q <= castle_rights;
                        sticky_w <= '0;
                        sticky_b <= '0;
                        cnt      <= '0;
                        state    <= S_GATHER;
                    end
                end
                S_GATHER: begin
                    white_map <= white_next;
                    black_map <= black_next;
                    sticky_w  <= sticky_w_next;
                    sticky_b  <= sticky_b_next;
                    if (all_reported) begin
                        state <= S_EVAL;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= S_DONE;
                        result_valid   <= 1'b1;
                        timeout_err    <= 1'b1;
                        white_in_check <= 1'b0;
                        black_in_check <= 1'b0;
                        castle_ok      <= '0;
`ifdef ATTACK_MAP_COUNT_EN
                        white_attack_count <= popcount(white_next);
                        black_attack_count <= popcount(black_next);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    state          <= S_DONE;
                    result_valid   <= 1'b1;
                    timeout_err    <= 1'b0;
                    white_in_check <= white_check_c;
                    black_in_check <= black_check_c;
                    castle_ok      <= castle_c;
`ifdef ATTACK_MAP_COUNT_EN
                    white_attack_count <= popcount(white_next);
                    black_attack_count <= popcount(black_next);
`endif
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attack_map_gather.sv
// Directed scoreboard bench for attack_map_gather: expected results are queued as each
// board's detector data is driven and compared when result_valid rises.

module tb_attack_map_gather;

    localparam logic [3:0] EMPTY = 4'd0;
    localparam logic [3:0] WP = 4'd1, WN = 4'd2, WB = 4'd3, WR = 4'd4, WQ = 4'd5, WK = 4'd6;
    localparam logic [3:0] BP = 4'd9, BN = 4'd10, BB = 4'd11, BR = 4'd12, BQ = 4'd13, BK = 4'd14;
    localparam logic [63:0] ALL = '1;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] board;
    logic         board_valid;
    logic [3:0]   castle_rights;
    logic [63:0]  white_attacked, white_attacked_valid;
    logic [63:0]  black_attacked, black_attacked_valid;
    logic         busy, result_valid, result_ready;
    logic [63:0]  white_map, black_map;
    logic         white_in_check, black_in_check;
    logic [3:0]   castle_ok;
    logic         timeout_err;
`ifdef ATTACK_MAP_COUNT_EN
    logic [6:0]   white_attack_count, black_attack_count;
`endif

    attack_map_gather dut (
        .clk                  (clk),
        .reset                (reset),
        .board                (board),
        .board_valid          (board_valid),
        .castle_rights        (castle_rights),
        .white_attacked       (white_attacked),
        .white_attacked_valid (white_attacked_valid),
        .black_attacked       (black_attacked),
        .black_attacked_valid (black_attacked_valid),
        .busy                 (busy),
        .result_valid         (result_valid),
        .result_ready         (result_ready),
        .white_map            (white_map),
        .black_map            (black_map),
        .white_in_check       (white_in_check),
        .black_in_check       (black_in_check),
        .castle_ok            (castle_ok),
        .timeout_err          (timeout_err)
`ifdef ATTACK_MAP_COUNT_EN
        ,
        .white_attack_count   (white_attack_count),
        .black_attack_count   (black_attack_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] wmap;
        logic [63:0] bmap;
        logic        wchk;
        logic        bchk;
        logic [3:0]  castle;
        logic        terr;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] mw = '0;
    logic [63:0] mb = '0;
    int          t0, tv;
    logic [255:0] start_pos, castle_pos;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] put(input logic [255:0] b, input int s, input logic [3:0] c);
        logic [255:0] r;
        r = b;
        r[s*4 +: 4] = c;
        return r;
    endfunction

    task automatic startBoard(input logic [255:0] b, input logic [3:0] r);
        board         = b;
        castle_rights = r;
        board_valid   = 1'b1;
        t0            = cyc;
        step();
        board_valid   = 1'b0;
    endtask

    // Drives one GATHER cycle of detector data and tracks the expected maps.
    task automatic applyStimulus(input logic [63:0] wa, input logic [63:0] wv,
                                 input logic [63:0] ba, input logic [63:0] bv);
        white_attacked       = wa;
        white_attacked_valid = wv;
        black_attacked       = ba;
        black_attacked_valid = bv;
        mw = (mw & ~wv) | (wa & wv);
        mb = (mb & ~bv) | (ba & bv);
        tv = cyc;
        step();
        white_attacked_valid = '0;
        black_attacked_valid = '0;
        white_attacked       = '0;
        black_attacked       = '0;
    endtask

    task automatic pushExpect(input logic wchk, input logic bchk, input logic [3:0] castle, input logic terr);
        exp_t e;
        e.wmap = mw;
        e.bmap = mb;
        e.wchk = wchk;
        e.bchk = bchk;
        e.castle = castle;
        e.terr = terr;
        sb.push_back(e);
    endtask

    task automatic waitResult(input int budget);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("result_valid_arrives", {63'd0, result_valid}, 64'd1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wmap"}, white_map, e.wmap);
            chk({tag, "_bmap"}, black_map, e.bmap);
            chk({tag, "_wchk"}, {63'd0, white_in_check}, {63'd0, e.wchk});
            chk({tag, "_bchk"}, {63'd0, black_in_check}, {63'd0, e.bchk});
            chk({tag, "_castle"}, {60'd0, castle_ok}, {60'd0, e.castle});
            chk({tag, "_terr"}, {63'd0, timeout_err}, {63'd0, e.terr});
            chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
`ifdef ATTACK_MAP_COUNT_EN
            chk({tag, "_wcount"}, {57'd0, white_attack_count}, 64'($countones(e.wmap)));
            chk({tag, "_bcount"}, {57'd0, black_attack_count}, 64'($countones(e.bmap)));
`endif
        end
    endtask

    task automatic releaseResult(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk({tag, "_rv_drop"}, {63'd0, result_valid}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_wmap_kept"}, white_map, mw);
    endtask

    initial begin
        start_pos = '0;
        start_pos = put(start_pos, 0, WR); start_pos = put(start_pos, 1, WN);
        start_pos = put(start_pos, 2, WB); start_pos = put(start_pos, 3, WQ);
        start_pos = put(start_pos, 4, WK); start_pos = put(start_pos, 5, WB);
        start_pos = put(start_pos, 6, WN); start_pos = put(start_pos, 7, WR);
        start_pos = put(start_pos, 56, BR); start_pos = put(start_pos, 57, BN);
        start_pos = put(start_pos, 58, BB); start_pos = put(start_pos, 59, BQ);
        start_pos = put(start_pos, 60, BK); start_pos = put(start_pos, 61, BB);
        start_pos = put(start_pos, 62, BN); start_pos = put(start_pos, 63, BR);
        for (int c = 0; c < 8; c++) begin
            start_pos = put(start_pos, 8 + c, WP);
            start_pos = put(start_pos, 48 + c, BP);
        end
        castle_pos = {64{EMPTY}};
        castle_pos = put(castle_pos, 0, WR);  castle_pos = put(castle_pos, 4, WK);
        castle_pos = put(castle_pos, 7, WR);  castle_pos = put(castle_pos, 56, BR);
        castle_pos = put(castle_pos, 60, BK); castle_pos = put(castle_pos, 63, BR);

        reset = 1'b0;
        board = '0;
        board_valid = 1'b0;
        castle_rights = '0;
        white_attacked = '0;
        white_attacked_valid = '0;
        black_attacked = '0;
        black_attacked_valid = '0;
        result_ready = 1'b0;
        step();
        step();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_rv", {63'd0, result_valid}, 64'd0);
        chk("reset_wmap", white_map, 64'd0);
        chk("reset_castle", {60'd0, castle_ok}, 64'd0);
        chk("reset_terr", {63'd0, timeout_err}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Start position, everything reported on the first GATHER cycle.
        startBoard(start_pos, 4'hF);
        chk("start_busy", {63'd0, busy}, 64'd1);
        applyStimulus(64'h0000_0000_00FF_FF00, ALL, 64'h00FF_FF00_0000_0000, ALL);
        pushExpect(1'b0, 1'b0, 4'h0, 1'b0);
        chk("start_rv_early", {63'd0, result_valid}, 64'd0);
        waitResult(20);
        chk("start_lat_board", 64'(cyc - t0), 64'd3);
        chk("start_lat_valid", 64'(cyc - tv), 64'd2);
        checkOutput("start");
        releaseResult("start");

        // Bare kings and rooks, valids spread over four cycles.
        startBoard(castle_pos, 4'hF);
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 64'hFFFF << (16 * i), '0, 64'hFFFF << (16 * i));
            if (i < 3) chk("spread_no_rv", {63'd0, result_valid}, 64'd0);
        end
        pushExpect(1'b0, 1'b0, 4'hF, 1'b0);
        waitResult(20);
        chk("spread_lat_valid", 64'(cyc - tv), 64'd2);
        checkOutput("spread");
        releaseResult("spread");

        startBoard(castle_pos, 4'hF);
        applyStimulus('0, ALL, 64'h20, ALL);
        pushExpect(1'b0, 1'b0, 4'hE, 1'b0);
        waitResult(20);
        checkOutput("f1_attacked");
        releaseResult("f1_attacked");

        startBoard(castle_pos, 4'hF);
        applyStimulus('0, ALL, 64'h30, ALL);
        pushExpect(1'b1, 1'b0, 4'hC, 1'b0);
        waitResult(20);
        checkOutput("e1_check");
        releaseResult("e1_check");

        startBoard(castle_pos, 4'hF);
        applyStimulus(64'd1 << 60, ALL, '0, ALL);
        pushExpect(1'b0, 1'b1, 4'h3, 1'b0);
        waitResult(20);
        checkOutput("e8_check");
        releaseResult("e8_check");

        // Square 63 never reports for white: expect a timeout after 15 GATHER cycles.
        startBoard(castle_pos, 4'hF);
        applyStimulus({64{1'b1}} ^ 64'h5555_5555_5555_5555, ~(64'd1 << 63), 64'h0F0F_0F0F_0F0F_0F0F, ALL);
        pushExpect(1'b0, 1'b0, 4'h0, 1'b1);
        waitResult(40);
        chk("timeout_lat", 64'(cyc - tv), 64'd15);
        checkOutput("timeout");
        for (int i = 0; i < 10; i++) begin
            board_valid = (i % 2 == 0);
            board = start_pos;
            step();
            chk("hold_rv", {63'd0, result_valid}, 64'd1);
            chk("hold_busy", {63'd0, busy}, 64'd1);
            chk("hold_terr", {63'd0, timeout_err}, 64'd1);
            chk("hold_wmap", white_map, mw);
        end
        board_valid = 1'b0;
        releaseResult("timeout");
        step();
        chk("ignored_pulses_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a gather.
        startBoard(castle_pos, 4'hF);
        applyStimulus(64'h1234, 64'h00FF_FFFF, 64'h5678, 64'h00FF_FFFF);
        chk("midreset_busy_before", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        mw = '0;
        mb = '0;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_rv", {63'd0, result_valid}, 64'd0);
        chk("midreset_wmap", white_map, 64'd0);
        chk("midreset_bmap", black_map, 64'd0);
        chk("midreset_terr", {63'd0, timeout_err}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        startBoard(castle_pos, 4'hF);
        applyStimulus('0, ALL, 64'h10, ALL);
        pushExpect(1'b1, 1'b0, 4'hC, 1'b0);
        waitResult(20);
        chk("after_reset_lat", 64'(cyc - t0), 64'd3);
        checkOutput("after_reset");
        releaseResult("after_reset");

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
